// File: rtl/ex_div_pkg.sv
// Shared definitions for the RV32M divide unit: data widths, reset value and
// funct3 operation codes.
package ex_div_pkg;

    localparam int DATA_WIDTH     = 32;
    localparam int REG_ADDR_WIDTH = 5;

    localparam logic [DATA_WIDTH-1:0] RST_DATA = '0;

    localparam logic [2:0] FUNCT3_DIV  = 3'b100;
    localparam logic [2:0] FUNCT3_DIVU = 3'b101;
    localparam logic [2:0] FUNCT3_REM  = 3'b110;
    localparam logic [2:0] FUNCT3_REMU = 3'b111;

    function automatic logic [DATA_WIDTH-1:0] abs_val(input logic [DATA_WIDTH-1:0] v);
        return v[DATA_WIDTH-1] ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/ex_div.sv
// Multi-cycle RV32M divider (DIV/DIVU/REM/REMU): restoring radix-2, one
// quotient bit per cycle, stalling the front of the pipeline while busy.
//
//   state | meaning
//   IDLE  | waiting for start_i; operands latched on accept
//   CALC  | 32 shift/subtract steps, counter 0..31
//   DONE  | apply sign correction, register result and pulse valid
module ex_div
    import ex_div_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start_i,
    input  logic [2:0]                funct3_i,
    input  logic [DATA_WIDTH-1:0]     op_data1_i,
    input  logic [DATA_WIDTH-1:0]     op_data2_i,
    input  logic [REG_ADDR_WIDTH-1:0] rd_addr_i,
    input  logic                      flush_i,
    output logic                      hold_req_o,
    output logic                      result_valid_o,
    output logic [DATA_WIDTH-1:0]     result_o,
    output logic [REG_ADDR_WIDTH-1:0] rd_addr_o,
    output logic                      busy_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                      state_q, state_d;
    logic [5:0]                  cnt_q, cnt_d;
    logic [2:0]                  funct3_q, funct3_d;
    logic [REG_ADDR_WIDTH-1:0]   rd_addr_q, rd_addr_d;
    logic [DATA_WIDTH-1:0]       quo_q, quo_d;
    logic [DATA_WIDTH-1:0]       rem_q, rem_d;
    logic [DATA_WIDTH-1:0]       dsr_q, dsr_d;
    logic                        neg_quo_q, neg_quo_d;
    logic                        neg_rem_q, neg_rem_d;
    logic [DATA_WIDTH-1:0]       result_q, result_d;
    logic [REG_ADDR_WIDTH-1:0]   rd_out_q, rd_out_d;
    logic                        valid_q, valid_d;

    logic                        hold_req;
    logic                        op_signed;
    logic                        op_is_rem;
    logic                        res_neg;
    logic [DATA_WIDTH:0]         rem_shift;
    logic [DATA_WIDTH:0]         rem_diff;
    logic [DATA_WIDTH-1:0]       mag;
    logic [DATA_WIDTH-1:0]       res_fix;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        funct3_d  = funct3_q;
        rd_addr_d = rd_addr_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        dsr_d     = dsr_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        result_d  = result_q;
        rd_out_d  = rd_out_q;
        valid_d   = 1'b0;
        hold_req  = 1'b0;

        op_signed = (funct3_i == FUNCT3_DIV) || (funct3_i == FUNCT3_REM);
        op_is_rem = (funct3_q == FUNCT3_REM) || (funct3_q == FUNCT3_REMU);

        // rem_q < dsr_q always holds, so bit DATA_WIDTH of the difference is a pure borrow flag
        rem_shift = {rem_q, quo_q[DATA_WIDTH-1]};
        rem_diff  = rem_shift - {1'b0, dsr_q};

        mag     = op_is_rem ? rem_q : quo_q;
        res_neg = op_is_rem ? neg_rem_q : neg_quo_q;
        res_fix = res_neg ? (~mag + 1'b1) : mag;

        if (flush_i) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        hold_req  = 1'b1;
                        funct3_d  = funct3_i;
                        rd_addr_d = rd_addr_i;
                        cnt_d     = '0;
                        // Divide by zero preloads the architectural result and skips CALC
                        if (op_data2_i == '0) begin
                            quo_d     = '1;
                            rem_d     = op_data1_i;
                            dsr_d     = '0;
                            neg_quo_d = 1'b0;
                            neg_rem_d = 1'b0;
                            state_d   = ST_DONE;
                        end else begin
                            quo_d     = op_signed ? abs_val(op_data1_i) : op_data1_i;
                            dsr_d     = op_signed ? abs_val(op_data2_i) : op_data2_i;
                            rem_d     = '0;
                            neg_quo_d = op_signed & (op_data1_i[DATA_WIDTH-1] ^ op_data2_i[DATA_WIDTH-1]);
                            neg_rem_d = op_signed & op_data1_i[DATA_WIDTH-1];
                            state_d   = ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    hold_req = 1'b1;
                    if (!rem_diff[DATA_WIDTH]) begin
                        rem_d = rem_diff[DATA_WIDTH-1:0];
                        quo_d = {quo_q[DATA_WIDTH-2:0], 1'b1};
                    end else begin
                        rem_d = rem_shift[DATA_WIDTH-1:0];
                        quo_d = {quo_q[DATA_WIDTH-2:0], 1'b0};
                    end
                    if (cnt_q == 6'd31) begin
                        cnt_d   = '0;
                        state_d = ST_DONE;
                    end else begin
                        cnt_d = cnt_q + 6'd1;
                    end
                end
                ST_DONE: begin
                    valid_d  = 1'b1;
                    result_d = res_fix;
                    rd_out_d = rd_addr_q;
                    state_d  = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            funct3_q  <= '0;
            rd_addr_q <= '0;
            quo_q     <= RST_DATA;
            rem_q     <= RST_DATA;
            dsr_q     <= RST_DATA;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= RST_DATA;
            rd_out_q  <= '0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            funct3_q  <= funct3_d;
            rd_addr_q <= rd_addr_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            dsr_q     <= dsr_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            result_q  <= result_d;
            rd_out_q  <= rd_out_d;
            valid_q   <= valid_d;
        end
    end

    assign hold_req_o     = hold_req;
    assign result_valid_o = valid_q;
    assign result_o       = result_q;
    assign rd_addr_o      = rd_out_q;
    assign busy_o         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ex_div.sv
// Self-checking bench for ex_div: directed vector table, flush/reset/ignored-start
// sequences, and randomized operations against an arithmetic reference model.
module tb_ex_div;
    import ex_div_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic [2:0]  funct3_i;
    logic [31:0] op_data1_i;
    logic [31:0] op_data2_i;
    logic [4:0]  rd_addr_i;
    logic        flush_i;
    logic        hold_req_o;
    logic        result_valid_o;
    logic [31:0] result_o;
    logic [4:0]  rd_addr_o;
    logic        busy_o;

    int checks = 0;
    int errors = 0;

    ex_div dut (
        .clk            (clk),
        .rst            (rst),
        .start_i        (start_i),
        .funct3_i       (funct3_i),
        .op_data1_i     (op_data1_i),
        .op_data2_i     (op_data2_i),
        .rd_addr_i      (rd_addr_i),
        .flush_i        (flush_i),
        .hold_req_o     (hold_req_o),
        .result_valid_o (result_valid_o),
        .result_o       (result_o),
        .rd_addr_o      (rd_addr_o),
        .busy_o         (busy_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: RISC-V divide semantics from plain 64-bit arithmetic
    function automatic logic [31:0] ref_div(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, r;
        bit sgn;
        bit is_rem;
        sgn    = (f == FUNCT3_DIV) || (f == FUNCT3_REM);
        is_rem = (f == FUNCT3_REM) || (f == FUNCT3_REMU);
        if (b == 32'd0) return is_rem ? a : 32'hFFFF_FFFF;
        sa = sgn ? longint'($signed(a)) : longint'({32'd0, a});
        sb = sgn ? longint'($signed(b)) : longint'({32'd0, b});
        r  = is_rem ? (sa % sb) : (sa / sb);
        return r[31:0];
    endfunction

    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, output logic [31:0] res, output logic [4:0] rdo,
                          output int lat, output int hold, output bit ok);
        ok   = 1'b0;
        lat  = 0;
        hold = 0;
        res  = '0;
        rdo  = '0;
        @(negedge clk);
        start_i    = 1'b1;
        funct3_i   = f;
        op_data1_i = a;
        op_data2_i = b;
        rd_addr_i  = rd;
        #1 hold += int'(hold_req_o);
        @(negedge clk);
        start_i    = 1'b0;
        op_data1_i = $urandom;
        op_data2_i = $urandom;
        rd_addr_i  = 5'($urandom);
        #1;
        for (int j = 0; j < 60; j++) begin
            if (result_valid_o) begin
                ok  = 1'b1;
                lat = j + 1;
                res = result_o;
                rdo = rd_addr_o;
                break;
            end
            hold += int'(hold_req_o);
            @(negedge clk);
            #1;
        end
    endtask

    initial begin
        logic [31:0] res;
        logic [31:0] exp;
        logic [4:0]  rdo;
        logic [4:0]  rd;
        logic [2:0]  f;
        logic [31:0] a, b;
        int          lat, hold, pulses;
        bit          ok, saw;

        tbl[0]  = '{FUNCT3_DIVU, 32'd100,        32'd7,          5'd1,  32'h0000_000E};
        tbl[1]  = '{FUNCT3_REMU, 32'd100,        32'd7,          5'd2,  32'h0000_0002};
        tbl[2]  = '{FUNCT3_DIV,  32'hFFFF_FF9C,  32'd7,          5'd3,  32'hFFFF_FFF2};
        tbl[3]  = '{FUNCT3_REM,  32'hFFFF_FF9C,  32'd7,          5'd4,  32'hFFFF_FFFE};
        tbl[4]  = '{FUNCT3_DIV,  32'h1234_5678,  32'd0,          5'd5,  32'hFFFF_FFFF};
        tbl[5]  = '{FUNCT3_REM,  32'h1234_5678,  32'd0,          5'd6,  32'h1234_5678};
        tbl[6]  = '{FUNCT3_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  5'd7,  32'h8000_0000};
        tbl[7]  = '{FUNCT3_REM,  32'h8000_0000,  32'hFFFF_FFFF,  5'd8,  32'h0000_0000};
        tbl[8]  = '{FUNCT3_DIVU, 32'hFFFF_FFFF,  32'd1,          5'd9,  32'hFFFF_FFFF};
        tbl[9]  = '{FUNCT3_REMU, 32'd5,          32'd0,          5'd10, 32'h0000_0005};
        tbl[10] = '{FUNCT3_DIV,  32'd7,          32'hFFFF_FFFE,  5'd11, 32'hFFFF_FFFD};
        tbl[11] = '{FUNCT3_REM,  32'd7,          32'hFFFF_FFFE,  5'd31, 32'h0000_0001};

        rst        = 1'b1;
        start_i    = 1'b0;
        funct3_i   = '0;
        op_data1_i = '0;
        op_data2_i = '0;
        rd_addr_i  = '0;
        flush_i    = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("reset_valid", 32'(result_valid_o), 32'd0);
        check("reset_hold",  32'(hold_req_o),     32'd0);
        check("reset_busy",  32'(busy_o),         32'd0);
        check("reset_result", result_o,           32'd0);
        check("reset_rd",    32'(rd_addr_o),      32'd0);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            run_op(tbl[i].f, tbl[i].a, tbl[i].b, tbl[i].rd, res, rdo, lat, hold, ok);
            check($sformatf("vec%0d_done", i), 32'(ok), 32'd1);
            check($sformatf("vec%0d_result", i), res, tbl[i].exp);
            check($sformatf("vec%0d_rd", i), 32'(rdo), 32'(tbl[i].rd));
            check($sformatf("vec%0d_latency", i), 32'(lat), (tbl[i].b == 0) ? 32'd2 : 32'd34);
            check($sformatf("vec%0d_hold_cycles", i), 32'(hold), (tbl[i].b == 0) ? 32'd1 : 32'd33);
            @(negedge clk);
            #1 check($sformatf("vec%0d_pulse_width", i), 32'(result_valid_o), 32'd0);
        end

        // Flush at CALC cycle 10: no result, then a normal DIVU 9/3
        @(negedge clk);
        start_i = 1'b1; funct3_i = FUNCT3_DIVU; op_data1_i = 32'd50000; op_data2_i = 32'd7; rd_addr_i = 5'd12;
        @(negedge clk);
        start_i = 1'b0;
        repeat (10) @(negedge clk);
        flush_i = 1'b1;
        #1 check("flush_hold_low", 32'(hold_req_o), 32'd0);
        @(negedge clk);
        flush_i = 1'b0;
        #1 check("flush_busy_low", 32'(busy_o), 32'd0);
        saw = 1'b0;
        repeat (40) begin
            @(negedge clk);
            #1 if (result_valid_o) saw = 1'b1;
        end
        check("flush_no_pulse", 32'(saw), 32'd0);
        run_op(FUNCT3_DIVU, 32'd9, 32'd3, 5'd13, res, rdo, lat, hold, ok);
        check("after_flush_done", 32'(ok), 32'd1);
        check("after_flush_result", res, 32'd3);

        // Reset at CALC cycle 5: outputs cleared at once, no pulse afterwards
        @(negedge clk);
        start_i = 1'b1; funct3_i = FUNCT3_DIVU; op_data1_i = 32'd1000; op_data2_i = 32'd3; rd_addr_i = 5'd14;
        @(negedge clk);
        start_i = 1'b0;
        repeat (5) @(negedge clk);
        #1 check("calc_busy", 32'(busy_o), 32'd1);
        rst = 1'b1;
        #1;
        check("midreset_valid", 32'(result_valid_o), 32'd0);
        check("midreset_hold",  32'(hold_req_o),     32'd0);
        check("midreset_busy",  32'(busy_o),         32'd0);
        check("midreset_result", result_o,           32'd0);
        check("midreset_rd",    32'(rd_addr_o),      32'd0);
        @(negedge clk);
        rst = 1'b0;
        saw = 1'b0;
        repeat (40) begin
            @(negedge clk);
            #1 if (result_valid_o) saw = 1'b1;
        end
        check("midreset_no_pulse", 32'(saw), 32'd0);
        run_op(FUNCT3_DIVU, 32'd1000, 32'd3, 5'd15, res, rdo, lat, hold, ok);
        check("after_reset_result", res, 32'd333);
        check("after_reset_latency", 32'(lat), 32'd34);

        // start_i raised in CALC and in DONE must be ignored
        @(negedge clk);
        start_i = 1'b1; funct3_i = FUNCT3_DIVU; op_data1_i = 32'd100; op_data2_i = 32'd7; rd_addr_i = 5'd3;
        pulses = 0;
        res = '0;
        rdo = '0;
        for (int j = 0; j < 80; j++) begin
            @(negedge clk);
            start_i    = (j == 5) || (j == 32);
            funct3_i   = FUNCT3_DIV;
            op_data1_i = 32'd7;
            op_data2_i = 32'd1;
            rd_addr_i  = 5'd9;
            #1;
            if (result_valid_o) begin
                pulses++;
                res = result_o;
                rdo = rd_addr_o;
            end
        end
        start_i = 1'b0;
        check("ignore_start_pulses", 32'(pulses), 32'd1);
        check("ignore_start_result", res, 32'h0000_000E);
        check("ignore_start_rd", 32'(rdo), 32'd3);

        for (int i = 0; i < 150; i++) begin
            f  = 3'b100 | 3'($urandom_range(0, 3));
            a  = $urandom;
            b  = $urandom;
            rd = 5'($urandom);
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 15));
                2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                3: b = 32'hFFFF_FFFF;
                4: a = 32'($urandom_range(0, 20));
                default: ;
            endcase
            exp = ref_div(f, a, b);
            run_op(f, a, b, rd, res, rdo, lat, hold, ok);
            if (!ok) begin
                checks++;
                errors++;
                $display("FAIL rand%0d_timeout: no result_valid_o within 60 cycles (f=%b a=%h b=%h)", i, f, a, b);
            end else begin
                check($sformatf("rand%0d_result f=%b a=%h b=%h", i, f, a, b), res, exp);
                check($sformatf("rand%0d_rd", i), 32'(rdo), 32'(rd));
                check($sformatf("rand%0d_latency", i), 32'(lat), (b == 0) ? 32'd2 : 32'd34);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
